// File: rtl/counter_stream_pkg.sv
// rtl/counter_stream_pkg.sv - shared types and constants for the counter-stream checker
//
// Purpose: word width, the transmitter restart word, the checker FSM state type
// and the modulo-2^16 successor helper used when seeding the expected word.
// Ports: none (package).
package counter_stream_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  // A transmitter coming out of reset restarts its counter at this value.
  localparam word_t RESTART_WORD = 16'h0000;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  // Successor of a received word; wraps 0xFFFF -> 0x0000 by truncation.
  function automatic word_t next_word(input word_t w);
    return w + word_t'(1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter used for the sequence error count
//
// Purpose: counts inc pulses and sticks at all-ones instead of wrapping.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset, clears the count
//   inc    in   add one this cycle (ignored once saturated)
//   cnt    out  current count, W bits
module sat_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/tt_um_counter_stream_checker.sv
// rtl/tt_um_counter_stream_checker.sv - receive-side checker for the 16-bit counter-stream link
//
// Purpose: samples {ui_in, uio_in} every enabled clock, locks onto the
// incrementing sequence and counts sequence errors while locked.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   ena      in   design enable; low freezes capture and all state
//   ui_in    in   received counter bits [15:8]
//   uio_in   in   received counter bits [7:0]
//   uo_out   out  {locked, err_sticky, err_cnt[5:0]}
//   uio_out  out  constant 0
//   uio_oe   out  constant 0, bidirectionals are inputs only
module tt_um_counter_stream_checker
  import counter_stream_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int ERR_W      = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  word_t       in_q, in_d;
  logic        have_q, have_d;        // in_q holds a captured word since reset
  state_e      state_q, state_d;
  word_t       expected_q, expected_d;
  logic [3:0]  run_q, run_d;
  logic        locked_q, locked_d;
  logic        err_sticky_q, err_sticky_d;
  logic        err_inc;
  logic [ERR_W-1:0] err_cnt;
  logic [5:0]  err_field;

  always_comb begin
    in_d         = in_q;
    have_d       = have_q;
    state_d      = state_q;
    expected_d   = expected_q;
    run_d        = run_q;
    locked_d     = locked_q;
    err_sticky_d = err_sticky_q;
    err_inc      = 1'b0;

    if (ena) begin
      in_d   = {ui_in, uio_in};
      have_d = 1'b1;

      // The word compared this edge is the one captured on the previous
      // enabled edge; the very first edge after reset only captures.
      if (have_q) begin
        unique case (state_q)
          ACQUIRE: begin
            expected_d = next_word(in_q);
            run_d      = '0;
            state_d    = TRACK;
          end

          TRACK: begin
            expected_d = next_word(in_q);
            if (in_q == expected_q) begin
              run_d = run_q + 4'd1;
              if (run_d == 4'(LOCK_COUNT)) begin
                state_d  = LOCKED;
                locked_d = 1'b1;
              end
            end else begin
              run_d = '0;
            end
          end

          LOCKED: begin
            if (in_q == expected_q) begin
              expected_d = next_word(in_q);
            end else if (in_q == RESTART_WORD) begin
              // Reaching here implies expected != RESTART_WORD, so a
              // transmitter reset is distinguished from a normal wrap.
              locked_d   = 1'b0;
              expected_d = next_word(RESTART_WORD);
              run_d      = '0;
              state_d    = TRACK;
            end else begin
              err_inc      = 1'b1;
              err_sticky_d = 1'b1;
              locked_d     = 1'b0;
              expected_d   = next_word(in_q);
              run_d        = '0;
              state_d      = TRACK;
            end
          end

          default: begin
            state_d = ACQUIRE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q         <= '0;
      have_q       <= 1'b0;
      state_q      <= ACQUIRE;
      expected_q   <= '0;
      run_q        <= '0;
      locked_q     <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      in_q         <= in_d;
      have_q       <= have_d;
      state_q      <= state_d;
      expected_q   <= expected_d;
      run_q        <= run_d;
      locked_q     <= locked_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (err_inc),
    .cnt  (err_cnt)
  );

  // The status word has a 6-bit count field regardless of ERR_W.
  generate
    if (ERR_W >= 6) begin : g_err_wide
      assign err_field = err_cnt[5:0];
    end else begin : g_err_narrow
      assign err_field = {{(6 - ERR_W){1'b0}}, err_cnt};
    end
  endgenerate

  assign uo_out  = {locked_q, err_sticky_q, err_field};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: doc/tt_um_counter_stream_checker.md
# tt_um_counter_stream_checker

- Receiving end of the team's 16-bit counter-stream link.
- A free-running transmitter drives its counter high byte and low byte onto two 8-bit buses; this block samples both buses every clock, locks onto the incrementing sequence and counts sequence errors.
- Sits as a standalone Tiny Tapeout user module, so a second die (or a loopback on the demo board) can check the transmitter at speed.

## Interface
Parameters:
- LOCK_COUNT, 4: consecutive correct increments required before declaring lock (1..15).
- ERR_W, 6: width of the saturating error counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- ena  input  1  design enable; when low, all state holds and input capture is frozen.
- ui_in  input  8  received counter bits [15:8].
- uio_in  input  8  received counter bits [7:0].
- uo_out  output  8  status word: {locked, err_sticky, err_cnt[5:0]}.
- uio_out  output  8  constant 0.
- uio_oe  output  8  constant 0; all bidirectionals are inputs.

## Operation
- Capture: word = {ui_in, uio_in}, registered into in_q every clock when ena=1.
- expected is a 16-bit register; increments use modulo-2^16 arithmetic, so 0xFFFF -> 0x0000 is a valid step.
- States: ACQUIRE, TRACK, LOCKED; reset state is ACQUIRE.
- ACQUIRE:
  - On the first compare cycle after reset: expected <= in_q+1, run <= 0, go to TRACK.
  - No error is counted.
- TRACK:
  - in_q == expected: run++, expected <= in_q+1. When run reaches LOCK_COUNT, go to LOCKED and set locked=1.
  - Mismatch: reseed (expected <= in_q+1, run <= 0), stay in TRACK, no error counted.
- LOCKED:
  - Match: expected <= in_q+1.
  - Mismatch with in_q == 0x0000 (transmitter reset): treated as a restart, not an error. locked <= 0, expected <= 0x0001, run <= 0, go to TRACK.
  - Any other mismatch: err_cnt++ (saturating at 2^ERR_W-1), err_sticky <= 1, locked <= 0, reseed expected <= in_q+1, run <= 0, go to TRACK.
- Restart exemption: only when expected != 0x0000. If expected == 0x0000 and in_q == 0x0000, it is a normal match.
- err_sticky and err_cnt clear only on reset.
- ena=0: in_q, state, expected, run, err_cnt and outputs all hold. On re-enable the held in_q is compared first.
- Reset values: uo_out=0x00, uio_out=0x00, uio_oe=0x00, state=ACQUIRE, expected=0, run=0.

## Timing
- Word on pins at rising edge k is captured in in_q at edge k.
- It is compared and its state and outputs are updated at edge k+1; uo_out is registered.
- Lock latency from the first valid word: that word seeds at edge 1. With LOCK_COUNT=4, locked rises at the edge that compares the 5th consecutive word.
- Error latency: err_cnt and err_sticky update at the edge that compares the bad word, i.e. one clock after capture.
- Reset mid-operation: all registers clear immediately (asynchronous). The first compare after release re-enters the ACQUIRE path.
- Simultaneous saturated err_cnt and a new error: err_cnt stays at max; err_sticky is already 1.

## Structure
- Package counter_stream_pkg holds:
  - the state enum (ACQUIRE, TRACK, LOCKED);
  - WORD_W=16;
  - RESTART_WORD=16'h0000.
- Sub-module sat_counter (parameter W; inputs clk, rst_n, inc; output cnt) implements the saturating error counter.
- The top level holds the capture register, expected/run registers, the FSM and output packing.

## Test plan
- Clean stream: after reset, drive 0x1230, 0x1231, ... -> locked=1 at the 5th compare edge; uo_out=0x80; err_cnt stays 0 for 100 words.
- Wrap: locked stream ..., 0xFFFE, 0xFFFF, 0x0000, 0x0001 -> no error, locked stays 1.
- Single bad word: locked at 0x0040, drive 0x0041, 0x0050, 0x0051, ... -> uo_out=0x41 one cycle after 0x0050 is captured; relock after 4 more matches gives uo_out=0xC1.
- Transmitter restart: locked at 0x2000, then drive 0x0000, 0x0001, ... -> no error; locked drops and relocks; err_cnt=0.
- Saturation: inject 70 isolated errors (each followed by a relock) -> err_cnt=63, uo_out=0xFF once relocked.
- ena/reset: ena low for 10 cycles while the pins change -> all state and outputs frozen. Assert rst_n low mid-stream -> uo_out=0x00 immediately, before any clock edge.
